// File: rtl/sr_latch_pkg.sv
// Shared types for the SR latch driver: command opcodes, FSM states, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: op_t (request opcode encoding), state_t (driver FSM), CNT_W and
// cnt_load(), which turns a cycle count into the value the down-counter starts at.
package sr_latch_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_RESET  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_READ   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // The counter is checked for zero before decrementing, so a phase of
  // N cycles starts the counter at N-1.
  function automatic cnt_t cnt_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/response channel between control logic and the SR latch driver.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response direction.
//
// Ports: req_valid/req_ready/req_op (command in), rsp_valid/rsp_ready/rsp_q/rsp_err
// (result out). master = control logic, slave = sr_latch_driver.
interface sr_latch_driver_if;
  import sr_latch_pkg::*;

  logic req_valid;
  logic req_ready;
  op_t  req_op;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_q;
  logic rsp_err;

  modport master (
    output req_valid, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_err
  );

  modport slave (
    input  req_valid, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_err
  );

endinterface

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchronizer bringing the free-running latch Q into the clk domain.
// Latency: 2 cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports: clk, rst (synchronous, active-high, clears both flops to 0), d (async in), q (sync out).
// Only needed when SR_READBACK_CHECK_EN is defined, so the module is compiled
// only in that build to keep the default build free of an unused module.
`ifdef SR_READBACK_CHECK_EN
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/sr_latch_driver.sv
// Drives set/reset pulses into NAND (sbar/rbar) and NOR (s/r) latch cells and reports the result.
// Latency: drive op accepted at edge N -> rsp_valid at edge N+PULSE_CYCLES+SETTLE_CYCLES; read -> N+SETTLE_CYCLES.
// Backpressure: one command in flight; req_ready only in IDLE; response held until rsp_ready.
//
// Ports: clk, rst (synchronous, active-high), bus (sr_latch_driver_if.slave),
// sbar/rbar (active-low latch inputs), s/r (active-high latch inputs), q_fb (latch Q, async).
// Parameters: PULSE_CYCLES (1..15), SETTLE_CYCLES (2..15).
// Build option SR_READBACK_CHECK_EN: Q is read back through sync_2ff and compared
// against the expected value; otherwise a shadow register stands in for Q and q_fb is ignored.
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  sr_latch_driver_if.slave         bus,
  output logic                     sbar,
  output logic                     rbar,
  output logic                     s,
  output logic                     r,
  input  logic                     q_fb
);

  localparam cnt_t PULSE_LOAD  = cnt_load(PULSE_CYCLES);
  localparam cnt_t SETTLE_LOAD = cnt_load(SETTLE_CYCLES);

  state_t state;
  cnt_t   cnt;
  logic   drv_set;     // resolved direction of the command in flight
  logic   is_read;
  logic   rsp_valid_r;
  logic   rsp_q_r;
  logic   rsp_err_r;
  logic   q_now;       // the block's current view of the latch state
  logic   res_set;

`ifdef SR_READBACK_CHECK_EN
  logic q_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_fb),
    .q   (q_sync)
  );

  assign q_now = q_sync;
`else
  logic shadow_q;
  logic unused_q_fb;

  assign unused_q_fb = q_fb;
  assign q_now       = shadow_q;
`endif

  // Toggle picks its direction from the latch state at acceptance time.
  assign res_set = (bus.req_op == OP_SET) ||
                   ((bus.req_op == OP_TOGGLE) && !q_now);

  assign bus.req_ready = (state == ST_IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_q     = rsp_q_r;
  assign bus.rsp_err   = rsp_err_r;

  // Latch pins are all written together so the complementary pairs can never
  // disagree and s/r are never both active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      drv_set     <= 1'b0;
      is_read     <= 1'b0;
      s           <= 1'b0;
      r           <= 1'b0;
      sbar        <= 1'b1;
      rbar        <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_q_r     <= 1'b0;
      rsp_err_r   <= 1'b0;
`ifndef SR_READBACK_CHECK_EN
      shadow_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            is_read <= (bus.req_op == OP_READ);
            drv_set <= res_set;
            if (bus.req_op == OP_READ) begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LOAD;
            end else begin
              state <= ST_PULSE;
              cnt   <= PULSE_LOAD;
              s     <= res_set;
              sbar  <= !res_set;
              r     <= !res_set;
              rbar  <= res_set;
            end
          end
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            state <= ST_SETTLE;
            cnt   <= SETTLE_LOAD;
            s     <= 1'b0;
            r     <= 1'b0;
            sbar  <= 1'b1;
            rbar  <= 1'b1;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) begin
            state       <= ST_RESP;
            rsp_valid_r <= 1'b1;
`ifdef SR_READBACK_CHECK_EN
            rsp_q_r     <= q_sync;
            rsp_err_r   <= !is_read && (q_sync != drv_set);
`else
            // Without readback the shadow is the latch state by definition.
            if (!is_read) begin
              shadow_q <= drv_set;
              rsp_q_r  <= drv_set;
            end else begin
              rsp_q_r  <= shadow_q;
            end
            rsp_err_r   <= 1'b0;
`endif
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous initiator for the set/reset latch cells. Accepts set, reset, toggle and read commands over a valid/ready request channel and drives both active-low NAND-style (sbar/rbar) and active-high NOR-style (s/r) latch inputs with timed, mutually exclusive pulses. It waits for the latch to settle, reads the latch Q back through a synchronizer, and returns the result on a valid/ready response channel. It sits between control logic and any free-running cross-coupled latch cell.

## Interface
- PULSE_CYCLES, 4: cycles a set/reset input is held active; legal 1–15
- SETTLE_CYCLES, 3: idle cycles after pulse before sampling Q; legal 2–15 (covers 2-flop sync)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high; the block has one clock
- req_valid  in  1  command present
- req_ready  out  1  block can accept a command
- req_op  in  2  00 set, 01 reset, 10 toggle, 11 read (no drive)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_q  out  1  latch state after command
- rsp_err  out  1  readback mismatch
- sbar, rbar  out  1 each  active-low latch inputs (NAND flavour)
- s, r  out  1 each  active-high latch inputs (NOR flavour)
- q_fb  in  1  latch Q, asynchronous to clk

## Operation
- FSM states: IDLE, PULSE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready: capture op. For toggle, resolve to set if current Q (see Configuration) is 0, else reset. Read goes to SETTLE, all others go to PULSE. Load the cycle counter.
- PULSE: drive the resolved input (set: sbar=0, s=1; reset: rbar=0, r=1) for exactly PULSE_CYCLES cycles, then go to SETTLE.
- SETTLE: all latch inputs inactive for SETTLE_CYCLES cycles, then go to RESP. Capture rsp_q and rsp_err on the transition.
- RESP: rsp_valid=1. rsp_q and rsp_err are held stable until rsp_ready; then return to IDLE.
- Invariant, every cycle including reset: never s&&r, never !sbar&&!rbar. sbar==!s and rbar==!r always.
- Expected Q: set → 1, reset → 0. A read never flags an error.
- Counter width is 4 bits. It decrements to 0 and never wraps.

## Timing
- All outputs are registered except req_ready = (state==IDLE)&&!rst.
- Reset values: sbar=1, rbar=1, s=0, r=0, rsp_valid=0, rsp_q=0, rsp_err=0, state IDLE, shadow Q=0.
- Reset mid-operation: latch inputs go inactive at the reset edge, any pending response is discarded, and no partial pulse is resumed.
- Drive command accepted at edge N: inputs active in cycles N+1..N+PULSE_CYCLES, rsp_valid rises at N+1+PULSE_CYCLES+SETTLE_CYCLES.
- Read accepted at N: rsp_valid rises at N+1+SETTLE_CYCLES.
- rsp_valid&&rsp_ready at edge M: req_ready=1 in cycle M+1. No back-to-back overlap, one command in flight.
- req_valid while not ready is ignored, with no side effects.

## Configuration
- SR_READBACK_CHECK_EN defined:
  - q_fb passes through a 2-flop synchronizer.
  - rsp_q = synchronized Q sampled at end of SETTLE.
  - rsp_err = (rsp_q != expected) for set/reset.
  - Toggle resolves from synchronized Q.
- Undefined:
  - q_fb is unused.
  - A shadow Q register updates on set/reset completion.
  - rsp_q = shadow, rsp_err tied 0.
  - Toggle resolves from shadow.

## Structure
- Package sr_latch_pkg:
  - op enum (OP_SET, OP_RESET, OP_TOGGLE, OP_READ)
  - state enum (ST_IDLE, ST_PULSE, ST_SETTLE, ST_RESP)
  - CNT_W=4
- Sub-module sync_2ff, a 1-bit two-flop synchronizer with reset value 0. It is instantiated only under SR_READBACK_CHECK_EN.

## Test plan
- Reset held 3 cycles, then idle: sbar=rbar=1, s=r=0, rsp_valid=0, req_ready=0 in reset and 1 after.
- Set accepted at cycle 10 (defaults), latch model attached: sbar=0/s=1 in cycles 11–14, rsp_valid at 18 with rsp_q=1, rsp_err=0.
- Toggle from Q=1: rbar=0/r=1 for 4 cycles, rsp_q=0. rsp_ready held low 5 cycles: rsp_valid and rsp_q stable, req_ready=0 throughout.
- With SR_READBACK_CHECK_EN, q_fb stuck at 0, set command: rsp_q=0, rsp_err=1. Read then gives rsp_q=0, rsp_err=0 at N+4.
- rst asserted in cycle 2 of PULSE: at the next edge sbar=1, s=0, state IDLE. No rsp_valid ever appears for that command.
- Random 1000-command run with random rsp_ready: assert s&&r and !sbar&&!rbar never occur, and pulse length is always exactly 4.
